// File: rtl/dot_product_stream_pkg.sv
// Shared types and default sizing for the serial dot-product block.
package dot_pkg;

    localparam int DOT_DATA_W  = 8;
    localparam int DOT_VEC_LEN = 4;
    localparam int DOT_ACC_W   = 2 * DOT_DATA_W + $clog2(DOT_VEC_LEN);

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } dot_state_e;

    typedef logic [DOT_DATA_W-1:0] elem_t;
    typedef logic [DOT_ACC_W-1:0]  acc_t;

endpackage

// File: rtl/dot_product_stream_mac.sv
// Combinational multiply-accumulate: sum = acc + ext(a*b).
// Define DOT_PRODUCT_STREAM_SIGNED_EN for two's-complement operands and sign extension.
module dot_mac #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 18
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [ACC_W-1:0]  acc,
    output logic [ACC_W-1:0]  sum
);

    logic signed [2*DATA_W-1:0] a_ext;
    logic signed [2*DATA_W-1:0] b_ext;
    logic signed [2*DATA_W-1:0] prod;
    logic        [ACC_W-1:0]    prod_ext;

    // Operands are widened to the full product width first, so the low
    // 2*DATA_W bits of the product are exact in either number format.
    always_comb begin
`ifdef DOT_PRODUCT_STREAM_SIGNED_EN
        a_ext    = {{DATA_W{a[DATA_W-1]}}, a};
        b_ext    = {{DATA_W{b[DATA_W-1]}}, b};
        prod     = a_ext * b_ext;
        prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
`else
        a_ext    = {{DATA_W{1'b0}}, a};
        b_ext    = {{DATA_W{1'b0}}, b};
        prod     = a_ext * b_ext;
        prod_ext = {{(ACC_W-2*DATA_W){1'b0}}, prod};
`endif
        sum = acc + prod_ext;
    end

endmodule

// File: rtl/dot_product_stream.sv
// Streaming serial dot product: one (a,b) pair per beat, result on a valid/ready output.
// Signed operation is selected with the DOT_PRODUCT_STREAM_SIGNED_EN macro.
module dot_product_stream
    import dot_pkg::*;
#(
    parameter int DATA_W  = DOT_DATA_W,
    parameter int VEC_LEN = DOT_VEC_LEN,
    parameter int ACC_W   = 2 * DATA_W + $clog2(VEC_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_result,
    output logic              busy
);

    localparam int CNT_W = $clog2(VEC_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

    dot_state_e       state;
    logic [CNT_W-1:0] count;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic             accept;

    dot_mac #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .a  (in_a),
        .b  (in_b),
        .acc(acc),
        .sum(sum)
    );

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign busy      = (count != '0) || (state == DONE);
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ACCUM;
            count      <= '0;
            acc        <= '0;
            out_result <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (count == LAST_IDX) begin
                            out_result <= sum;
                            count      <= '0;
                            state      <= DONE;
                        end else begin
                            acc   <= sum;
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    // Result stays on out_result until the consumer takes it.
                    if (out_ready) begin
                        acc   <= '0;
                        state <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_stream.sv
// Self-checking bench for dot_product_stream with a behavioural dot-product model.
module tb_dot_product_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_result;
    logic        busy;

    int total  = 0;
    int passed = 0;

    dot_product_stream dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [17:0] ref_dot(input logic [7:0] a[4], input logic [7:0] b[4]);
        int s = 0;
        for (int i = 0; i < 4; i++) begin
            int x = int'(a[i]);
            int y = int'(b[i]);
`ifdef DOT_PRODUCT_STREAM_SIGNED_EN
            if (x > 127) x -= 256;
            if (y > 127) y -= 256;
`endif
            s += x * y;
        end
        return s[17:0];
    endfunction

    // Tasks begin and end at a falling edge; one beat spans one rising edge.
    task automatic beat(input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        @(negedge clk);
        in_valid = 1'b0;
        in_a = 8'($urandom);
        in_b = 8'($urandom);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_a = 8'($urandom);
        in_b = 8'($urandom);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
        @(negedge clk);
        @(negedge clk);
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
        total++; if (out_result !== 18'd0) $display("FAIL reset_out_result: got %0d expected 0", out_result); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        rst = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else passed++;
    endtask

    task automatic test_basic();
        logic [7:0] a[4] = '{8'd1, 8'd2, 8'd3, 8'd4};
        logic [7:0] b[4] = '{8'd5, 8'd6, 8'd7, 8'd8};
        logic [17:0] exp = ref_dot(a, b);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            beat(a[i], b[i]);
            if (i < 3) begin
                total++; if (out_valid !== 1'b0) $display("FAIL basic_early_valid: beat %0d got %b expected 0", i, out_valid); else passed++;
            end
        end
        total++; if (exp !== 18'd70) $display("FAIL basic_model: got %0d expected 70", exp); else passed++;
        total++; if (out_valid !== 1'b1) $display("FAIL basic_out_valid: got %b expected 1", out_valid); else passed++;
        total++; if (out_result !== exp) $display("FAIL basic_result: got %0d expected %0d", out_result, exp); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL basic_in_ready_done: got %b expected 0", in_ready); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL basic_busy_done: got %b expected 1", busy); else passed++;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) $display("FAIL basic_valid_one_cycle: got %b expected 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL basic_in_ready_back: got %b expected 1", in_ready); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL basic_busy_idle: got %b expected 0", busy); else passed++;
    endtask

    task automatic test_max();
        logic [7:0] a[4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        logic [17:0] exp = ref_dot(a, a);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) beat(8'hFF, 8'hFF);
        total++; if (out_result !== exp) $display("FAIL max_result: got %0d expected %0d", out_result, exp); else passed++;
`ifndef DOT_PRODUCT_STREAM_SIGNED_EN
        total++; if (out_result !== 18'h3F804) $display("FAIL max_result_const: got %0d expected 260100", out_result); else passed++;
`endif
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [7:0] a[4] = '{8'd2, 8'd2, 8'd2, 8'd2};
        logic [7:0] o[4] = '{8'd1, 8'd1, 8'd1, 8'd1};
        logic [17:0] exp = ref_dot(a, a);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) beat(8'd2, 8'd2);
        for (int c = 0; c < 5; c++) begin
            total++; if (out_valid !== 1'b1) $display("FAIL bp_valid: cycle %0d got %b expected 1", c, out_valid); else passed++;
            total++; if (out_result !== exp) $display("FAIL bp_result: cycle %0d got %0d expected %0d", c, out_result, exp); else passed++;
            total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: cycle %0d got %b expected 0", c, in_ready); else passed++;
            in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) $display("FAIL bp_handshake: got %b expected 0", out_valid); else passed++;
        for (int i = 0; i < 4; i++) beat(8'd1, 8'd1);
        total++; if (out_result !== ref_dot(o, o)) $display("FAIL bp_second_result: got %0d expected %0d", out_result, ref_dot(o, o)); else passed++;
        @(negedge clk);
    endtask

    task automatic test_gaps();
        logic [7:0] a[4] = '{8'd2, 8'd4, 8'd6, 8'd1};
        logic [7:0] b[4] = '{8'd3, 8'd5, 8'd7, 8'd1};
        logic       pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [17:0] exp = ref_dot(a, b);
        int k = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (pat[c]) begin
                beat(a[k], b[k]);
                k++;
            end else begin
                idle();
                total++; if (busy !== 1'b1) $display("FAIL gaps_busy: cycle %0d got %b expected 1", c, busy); else passed++;
            end
        end
        total++; if (out_valid !== 1'b1) $display("FAIL gaps_valid: got %b expected 1", out_valid); else passed++;
        total++; if (out_result !== exp) $display("FAIL gaps_result: got %0d expected %0d", out_result, exp); else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [7:0] a[4] = '{8'd1, 8'd1, 8'd1, 8'd1};
        logic [7:0] b[4] = '{8'd2, 8'd2, 8'd2, 8'd2};
        logic [7:0] t[4] = '{8'd3, 8'd3, 8'd3, 8'd3};
        out_ready = 1'b1;
        beat(8'd10, 8'd10);
        beat(8'd10, 8'd10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy); else passed++;
        for (int i = 0; i < 4; i++) beat(a[i], b[i]);
        total++; if (out_result !== ref_dot(a, b)) $display("FAIL rstmid_result: got %0d expected %0d", out_result, ref_dot(a, b)); else passed++;
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) beat(t[i], t[i]);
        total++; if (out_valid !== 1'b1) $display("FAIL rstdone_pre_valid: got %b expected 1", out_valid); else passed++;
        #2 rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL rstdone_async_drop: got %b expected 0", out_valid); else passed++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL rstdone_recover: got in_ready=%b busy=%b expected 1/0", in_ready, busy); else passed++;
    endtask

    task automatic test_signed_mode();
        logic [7:0] a[4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        logic [7:0] b[4] = '{8'h02, 8'h02, 8'h02, 8'h02};
        logic [17:0] exp;
`ifdef DOT_PRODUCT_STREAM_SIGNED_EN
        exp = 18'h3FFF8;
`else
        exp = 18'd2040;
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) beat(a[i], b[i]);
        total++; if (out_result !== exp) $display("FAIL signed_result: got 0x%0h expected 0x%0h", out_result, exp); else passed++;
        total++; if (ref_dot(a, b) !== out_result) $display("FAIL signed_model: got 0x%0h expected 0x%0h", out_result, ref_dot(a, b)); else passed++;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [7:0] a[4];
        logic [7:0] b[4];
        logic [17:0] exp;
        int hold;
        for (int v = 0; v < 25; v++) begin
            for (int i = 0; i < 4; i++) begin
                a[i] = 8'($urandom);
                b[i] = 8'($urandom);
            end
            exp = ref_dot(a, b);
            out_ready = 1'b0;
            for (int i = 0; i < 4; i++) begin
                repeat ($urandom_range(0, 2)) idle();
                beat(a[i], b[i]);
            end
            hold = $urandom_range(0, 3);
            for (int c = 0; c < hold; c++) begin
                total++; if (out_valid !== 1'b1 || out_result !== exp) $display("FAIL rand_hold: vec %0d got valid=%b result=%0d expected 1/%0d", v, out_valid, out_result, exp); else passed++;
                in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom);
                @(negedge clk);
                in_valid = 1'b0;
            end
            total++; if (out_valid !== 1'b1 || out_result !== exp) $display("FAIL rand_result: vec %0d got valid=%b result=%0d expected 1/%0d", v, out_valid, out_result, exp); else passed++;
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            total++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rand_handoff: vec %0d got valid=%b busy=%b expected 0/0", v, out_valid, busy); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_backpressure();
        test_gaps();
        test_reset_mid();
        test_signed_mode();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
